lif_spike_monitor: RTL and testbench



---
 rtl/lif_pkg.sv | 25 ++
 rtl/lif_isi_meter.sv | 60 ++++++
 rtl/lif_spike_monitor.sv | 120 ++++++++++++
 tb/tb_lif_spike_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF spike monitor.
// Holds the monitor FSM state type, the default widths and a saturating add.
// Latency: n/a. Backpressure: n/a (no handshake interfaces).
package lif_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 12;
    localparam int ISI_W_DEF = 12;

    // Adds inc to v, clamping the result at maxv.
    // The caller narrows the result back to its own register width.
    function automatic int unsigned sat_inc(input int unsigned v,
                                            input int unsigned inc,
                                            input int unsigned maxv);
        int unsigned s;
        s = v + inc;
        return ((s > maxv) || (s < v)) ? maxv : s;
    endfunction

endpackage

// File: rtl/lif_isi_meter.sv
// Inter-spike interval meter: counts cycles between consecutive spike edges.
// Latency: isi/isi_valid appear the cycle after the second edge; no backpressure.
// Ports: i_clk/i_rst, i_run (counting enabled), i_edge (one-cycle spike edge),
//        o_isi (last interval), o_isi_valid (update pulse), o_isi_ovf (interval saturated).
module lif_isi_meter
    import lif_pkg::*;
#(
    parameter int ISI_W = ISI_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_edge,
    output logic [ISI_W-1:0] o_isi,
    output logic             o_isi_valid,
    output logic             o_isi_ovf
);

    localparam int unsigned ISI_MAX = (32'd1 << ISI_W) - 32'd1;

    logic [ISI_W-1:0] r_timer;
    logic             r_armed;
    logic [ISI_W-1:0] r_isi;
    logic             r_isi_valid;
    logic             r_isi_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer     <= '0;
            r_armed     <= 1'b0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
            r_isi_ovf   <= 1'b0;
        end else begin
            r_isi_valid <= 1'b0;
            if (!i_run) begin
                // Leaving RUN forgets the previous spike, so the first edge
                // after re-enable only arms the meter.
                r_timer <= '0;
                r_armed <= 1'b0;
            end else if (i_edge) begin
                // Timer restarts at 1 so it reads t1-t0 on the next edge.
                r_timer <= ISI_W'(1);
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_isi       <= r_timer;
                    r_isi_ovf   <= (r_timer == ISI_W'(ISI_MAX));
                    r_isi_valid <= 1'b1;
                end
            end else begin
                r_timer <= ISI_W'(sat_inc(32'(r_timer), 32'd1, ISI_MAX));
            end
        end
    end

    assign o_isi       = r_isi;
    assign o_isi_valid = r_isi_valid;
    assign o_isi_ovf   = r_isi_ovf;

endmodule

// File: rtl/lif_spike_monitor.sv
// LIF spike monitor: windowed spike rate with burst flag, plus inter-spike interval.
// Latency: results visible the cycle after the window's last cycle / the closing edge.
// Backpressure: none; outputs are pulses plus held registers.
// Ports: i_en run enable, i_spike level spike, i_win_len window-1, i_burst_thr threshold;
//        o_rate_count/o_rate_valid/o_burst rate results, o_isi/o_isi_valid/o_isi_ovf ISI results.
module lif_spike_monitor
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int ISI_W = ISI_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_spike,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [CNT_W-1:0] i_burst_thr,
    output logic [CNT_W-1:0] o_rate_count,
    output logic             o_rate_valid,
    output logic             o_burst,
    output logic [ISI_W-1:0] o_isi,
    output logic             o_isi_valid,
    output logic             o_isi_ovf
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_spike_q;
    logic [WIN_W-1:0] r_wcnt;
    logic [WIN_W-1:0] r_win_len_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rate_count;
    logic             r_rate_valid;
    logic             r_burst;

    logic             w_edge;
    logic             w_run;
    logic             w_win_end;
    logic [CNT_W-1:0] w_cnt_inc;

    // spike_q tracks the input in every state, so a spike already high when
    // RUN begins does not register as an edge.
    assign w_edge    = i_spike & ~r_spike_q;
    // A RUN cycle with en low is the exit cycle: nothing is counted in it.
    assign w_run     = (r_state == RUN) && i_en;
    assign w_win_end = w_run && (r_wcnt == r_win_len_q);
    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), 32'(w_edge), CNT_MAX));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en)  w_state_nxt = RUN;
            RUN:     if (!i_en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spike_q    <= 1'b0;
            r_wcnt       <= '0;
            r_win_len_q  <= '0;
            r_cnt        <= '0;
            r_rate_count <= '0;
            r_rate_valid <= 1'b0;
            r_burst      <= 1'b0;
        end else begin
            r_spike_q    <= i_spike;
            r_rate_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_wcnt <= '0;
                r_cnt  <= '0;
                if (i_en) r_win_len_q <= i_win_len;
            end else if (!i_en) begin
                // Partial window is dropped; published results stay put.
                r_wcnt <= '0;
                r_cnt  <= '0;
            end else if (w_win_end) begin
                // Edge in the last cycle belongs to the closing window.
                r_rate_count <= w_cnt_inc;
                r_burst      <= (w_cnt_inc >= i_burst_thr);
                r_rate_valid <= 1'b1;
                r_cnt        <= '0;
                r_wcnt       <= '0;
                r_win_len_q  <= i_win_len;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_wcnt <= r_wcnt + WIN_W'(1);
            end
        end
    end

    lif_isi_meter #(
        .ISI_W (ISI_W)
    ) u_isi (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run       (w_run),
        .i_edge      (w_edge),
        .o_isi       (o_isi),
        .o_isi_valid (o_isi_valid),
        .o_isi_ovf   (o_isi_ovf)
    );

    assign o_rate_count = r_rate_count;
    assign o_rate_valid = r_rate_valid;
    assign o_burst      = r_burst;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: a default-width instance and a
// narrow (CNT_W=4, ISI_W=4) instance share stimulus; the narrow one covers saturation.
module tb_lif_spike_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic        spike;
    logic [11:0] win_len;
    logic [7:0]  thr_a;
    logic [3:0]  thr_b;

    logic [7:0]  rc_a;
    logic        rv_a;
    logic        bu_a;
    logic [11:0] isi_a;
    logic        iv_a;
    logic        io_a;

    logic [3:0]  rc_b;
    logic        rv_b;
    logic        bu_b;
    logic [3:0]  isi_b;
    logic        iv_b;
    logic        io_b;

    int errors = 0;
    int checks = 0;

    lif_spike_monitor #(.CNT_W(8), .WIN_W(12), .ISI_W(12)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_spike(spike),
        .i_win_len(win_len), .i_burst_thr(thr_a),
        .o_rate_count(rc_a), .o_rate_valid(rv_a), .o_burst(bu_a),
        .o_isi(isi_a), .o_isi_valid(iv_a), .o_isi_ovf(io_a)
    );

    lif_spike_monitor #(.CNT_W(4), .WIN_W(12), .ISI_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_spike(spike),
        .i_win_len(win_len), .i_burst_thr(thr_b),
        .o_rate_count(rc_b), .o_rate_valid(rv_b), .o_burst(bu_b),
        .o_isi(isi_b), .o_isi_valid(iv_b), .o_isi_ovf(io_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set before this call are sampled at the edge,
    // outputs are read 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; spike = 1'b0; win_len = 12'd0;
        thr_a = 8'd4; thr_b = 4'd15;
        repeat (3) tick();
        if (rc_a !== 8'd0) begin errors++; $display("FAIL reset_rate_count: got %0d want 0", rc_a); end
        checks++;
        if (rv_a !== 1'b0) begin errors++; $display("FAIL reset_rate_valid: got %b want 0", rv_a); end
        checks++;
        if (bu_a !== 1'b0) begin errors++; $display("FAIL reset_burst: got %b want 0", bu_a); end
        checks++;
        if (isi_a !== 12'd0) begin errors++; $display("FAIL reset_isi: got %0d want 0", isi_a); end
        checks++;
        if ({iv_a, io_a} !== 2'b00) begin errors++; $display("FAIL reset_isi_flags: got %b want 00", {iv_a, io_a}); end
        checks++;
        if ({rc_b, rv_b, bu_b, isi_b, iv_b, io_b} !== 12'd0) begin
            errors++; $display("FAIL reset_narrow: got %h want 0", {rc_b, rv_b, bu_b, isi_b, iv_b, io_b});
        end
        checks++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_window_burst;
        int nv;
        nv = 0;
        en = 1'b1; win_len = 12'd9;
        tick();
        for (int c = 0; c < 10; c++) begin
            spike = (c % 3 == 0);
            tick();
            if (c < 9) nv += int'(rv_a);
            if (c == 3) begin
                if ({iv_a, isi_a} !== {1'b1, 12'd3}) begin
                    errors++; $display("FAIL win_isi3: got valid=%b isi=%0d want valid=1 isi=3", iv_a, isi_a);
                end
                checks++;
            end
        end
        if (nv !== 0) begin errors++; $display("FAIL win1_early_valid: got %0d pulses want 0", nv); end
        checks++;
        if (rc_a !== 8'd4) begin errors++; $display("FAIL win1_count: got %0d want 4", rc_a); end
        checks++;
        if (rv_a !== 1'b1) begin errors++; $display("FAIL win1_valid: got %b want 1", rv_a); end
        checks++;
        if (bu_a !== 1'b1) begin errors++; $display("FAIL win1_burst: got %b want 1", bu_a); end
        checks++;
        spike = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) begin
                if (rv_a !== 1'b0) begin errors++; $display("FAIL win1_valid_width: got %b want 0", rv_a); end
                checks++;
            end
            if (c < 9) nv += int'(rv_a);
        end
        if (nv !== 0) begin errors++; $display("FAIL win2_early_valid: got %0d pulses want 0", nv); end
        checks++;
        if ({rv_a, rc_a, bu_a} !== {1'b1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL win2_empty: got valid=%b count=%0d burst=%b want 1/0/0", rv_a, rc_a, bu_a);
        end
        checks++;
    endtask

    task automatic test_level_spike;
        for (int c = 0; c < 10; c++) begin
            spike = (c >= 2 && c <= 6);
            tick();
        end
        spike = 1'b0;
        if ({rv_a, rc_a} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL level_count: got valid=%b count=%0d want 1/1", rv_a, rc_a);
        end
        checks++;
    endtask

    task automatic test_isi;
        int ni;
        ni = 0;
        en = 1'b0;
        tick(); tick();
        en = 1'b1; win_len = 12'd99;
        tick();
        for (int c = 0; c < 29; c++) begin
            spike = (c == 20 || c == 27);
            tick();
            if (c < 27) ni += int'(iv_a);
            if (c == 27) begin
                if ({iv_a, isi_a, io_a} !== {1'b1, 12'd7, 1'b0}) begin
                    errors++; $display("FAIL isi_7: got valid=%b isi=%0d ovf=%b want 1/7/0", iv_a, isi_a, io_a);
                end
                checks++;
            end
            if (c == 28) begin
                if (iv_a !== 1'b0) begin errors++; $display("FAIL isi_valid_width: got %b want 0", iv_a); end
                checks++;
            end
        end
        spike = 1'b0;
        if (ni !== 0) begin errors++; $display("FAIL isi_first_edge: got %0d pulses want 0", ni); end
        checks++;
    endtask

    task automatic test_saturation;
        en = 1'b0;
        tick(); tick();
        en = 1'b1; win_len = 12'd63;
        tick();
        for (int c = 0; c < 64; c++) begin
            spike = (c % 2 == 0);
            tick();
        end
        if ({rv_b, rc_b, bu_b} !== {1'b1, 4'd15, 1'b1}) begin
            errors++; $display("FAIL sat_count: got valid=%b count=%0d burst=%b want 1/15/1", rv_b, rc_b, bu_b);
        end
        checks++;
        if (rc_a !== 8'd32) begin errors++; $display("FAIL wide_count32: got %0d want 32", rc_a); end
        checks++;
        for (int c = 0; c < 21; c++) begin
            spike = (c == 0 || c == 20);
            tick();
        end
        spike = 1'b0;
        if ({iv_b, isi_b, io_b} !== {1'b1, 4'd15, 1'b1}) begin
            errors++; $display("FAIL sat_isi: got valid=%b isi=%0d ovf=%b want 1/15/1", iv_b, isi_b, io_b);
        end
        checks++;
        if ({iv_a, isi_a, io_a} !== {1'b1, 12'd20, 1'b0}) begin
            errors++; $display("FAIL wide_isi20: got valid=%b isi=%0d ovf=%b want 1/20/0", iv_a, isi_a, io_a);
        end
        checks++;
    endtask

    task automatic test_enable_drop;
        int nv;
        int ni;
        nv = 0; ni = 0;
        en = 1'b0;
        tick(); tick();
        en = 1'b1; win_len = 12'd9;
        tick();
        for (int c = 0; c < 5; c++) begin
            spike = (c == 1);
            tick();
            nv += int'(rv_a);
            ni += int'(iv_a);
        end
        en = 1'b0; spike = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            nv += int'(rv_a);
        end
        if (nv !== 0) begin errors++; $display("FAIL drop_no_valid: got %0d pulses want 0", nv); end
        checks++;
        if (ni !== 0) begin errors++; $display("FAIL drop_first_edge: got %0d pulses want 0", ni); end
        checks++;
        if ({rc_a, bu_a, isi_a} !== {8'd32, 1'b1, 12'd20}) begin
            errors++; $display("FAIL drop_hold: got count=%0d burst=%b isi=%0d want 32/1/20", rc_a, bu_a, isi_a);
        end
        checks++;
        nv = 0; ni = 0;
        en = 1'b1; win_len = 12'd3;
        tick();
        for (int c = 0; c < 4; c++) begin
            spike = (c == 1);
            tick();
            if (c < 3) nv += int'(rv_a);
            ni += int'(iv_a);
        end
        spike = 1'b0;
        if (nv !== 0) begin errors++; $display("FAIL reen_early_valid: got %0d pulses want 0", nv); end
        checks++;
        if ({rv_a, rc_a, bu_a} !== {1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL reen_window: got valid=%b count=%0d burst=%b want 1/1/0", rv_a, rc_a, bu_a);
        end
        checks++;
        if (ni !== 0) begin errors++; $display("FAIL reen_first_edge: got %0d pulses want 0", ni); end
        checks++;
    endtask

    task automatic test_reset_midop;
        int nv;
        nv = 0;
        spike = 1'b0;
        rst = 1'b1;
        tick();
        if ({rc_a, rv_a, bu_a} !== 10'd0) begin
            errors++; $display("FAIL midrst_rate: got count=%0d valid=%b burst=%b want 0/0/0", rc_a, rv_a, bu_a);
        end
        checks++;
        if ({isi_a, iv_a, io_a} !== 14'd0) begin
            errors++; $display("FAIL midrst_isi: got isi=%0d valid=%b ovf=%b want 0/0/0", isi_a, iv_a, io_a);
        end
        checks++;
        rst = 1'b0; en = 1'b1; win_len = 12'd3;
        tick();
        nv += int'(rv_a);
        for (int c = 0; c < 4; c++) begin
            spike = (c == 0 || c == 2);
            tick();
            if (c < 3) nv += int'(rv_a);
            if (c == 0) begin
                if (iv_a !== 1'b0) begin errors++; $display("FAIL midrst_first_edge: got %b want 0", iv_a); end
                checks++;
            end
            if (c == 2) begin
                if ({iv_a, isi_a} !== {1'b1, 12'd2}) begin
                    errors++; $display("FAIL midrst_isi2: got valid=%b isi=%0d want 1/2", iv_a, isi_a);
                end
                checks++;
            end
        end
        spike = 1'b0;
        if (nv !== 0) begin errors++; $display("FAIL midrst_early_valid: got %0d pulses want 0", nv); end
        checks++;
        if ({rv_a, rc_a} !== {1'b1, 8'd2}) begin
            errors++; $display("FAIL midrst_window: got valid=%b count=%0d want 1/2", rv_a, rc_a);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_window_burst();
        test_level_spike();
        test_isi();
        test_saturation();
        test_enable_drop();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
